// File: rtl/dpi_sync_pkg.sv
// Shared definitions for the DPI sync lock controller: FSM encoding and
// default sizing of the timing counters and lock qualification.
package dpi_sync_pkg;

    localparam int DEF_CNT_W       = 12;
    localparam int DEF_LOCK_FRAMES = 4;

    // match_cnt width; LOCK_FRAMES is limited to 1..15
    localparam int MATCH_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

endpackage

// File: rtl/dpi_sync_lock_ctrl_period.sv
// dpi_period_counter: rising-edge detector on a sync input plus a saturating
// counter of 'tick' events since that edge, with period and timeout outputs.
module dpi_period_counter
    import dpi_sync_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    // 0: counter restarts at 0 on the edge and period = cnt + 1.
    // 1: a tick coincident with the edge is the first event of the new
    //    interval, so the counter restarts at that tick and period = cnt.
    parameter bit EDGE_COUNTS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             tick,
    output logic             sig_d,
    output logic             rise,
    output logic [CNT_W-1:0] period,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;

    assign rise    = sig_in & ~sig_d;
    assign timeout = (cnt == CNT_MAX);
    assign period  = EDGE_COUNTS ? cnt : (cnt + CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_d <= 1'b0;
            cnt   <= '0;
        end else begin
            sig_d <= sig_in;
            if (rise) begin
                cnt <= EDGE_COUNTS ? {{(CNT_W-1){1'b0}}, tick} : '0;
            end else if (tick && !timeout) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/dpi_sync_lock_ctrl.sv
// DPI timing qualifier: measures line period and lines per frame, locks after
// LOCK_FRAMES identical good frames and blanks pixel data until locked.
module dpi_sync_lock_ctrl
    import dpi_sync_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic               clk_video,
    input  logic               reset_n,
    input  logic [23:0]        rgb_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [23:0]        rgb_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               locked,
    output logic               unlock_pulse,
    output logic [CNT_W-1:0]   h_total,
    output logic [CNT_W-1:0]   v_total,
    output logic [1:0]         state_dbg,
    output logic [MATCH_W-1:0] match_cnt_dbg
);

    localparam logic [MATCH_W-1:0] MATCH_ONE   = {{(MATCH_W-1){1'b0}}, 1'b1};
    localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_FRAMES);

    logic             hrise;
    logic             vrise;
    logic             h_tmo;
    logic             v_sat;
    logic [CNT_W-1:0] h_period;
    logic [CNT_W-1:0] v_meas;

    // Line timing: counts every clock between hsync rising edges.
    dpi_period_counter #(
        .CNT_W       (CNT_W),
        .EDGE_COUNTS (1'b0)
    ) u_line_cnt (
        .clk     (clk_video),
        .rst_n   (reset_n),
        .sig_in  (hsync_in),
        .tick    (1'b1),
        .sig_d   (hsync_out),
        .rise    (hrise),
        .period  (h_period),
        .timeout (h_tmo)
    );

    // Frame timing: counts hsync edges between vsync edges.
    dpi_period_counter #(
        .CNT_W       (CNT_W),
        .EDGE_COUNTS (1'b1)
    ) u_frame_cnt (
        .clk     (clk_video),
        .rst_n   (reset_n),
        .sig_in  (vsync_in),
        .tick    (hrise),
        .sig_d   (vsync_out),
        .rise    (vrise),
        .period  (v_meas),
        .timeout (v_sat)
    );

    logic [CNT_W-1:0] line_ref;
    logic             ref_valid;
    logic             frame_ok;
    logic             frame_tmo;

    // Per-frame line consistency; an hrise coincident with vrise starts the
    // new frame, so its period is not taken as that frame's reference.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            line_ref  <= '0;
            ref_valid <= 1'b0;
            frame_ok  <= 1'b0;
            frame_tmo <= 1'b0;
        end else if (vrise) begin
            ref_valid <= 1'b0;
            frame_ok  <= 1'b1;
            frame_tmo <= 1'b0;
        end else begin
            if (h_tmo) begin
                frame_tmo <= 1'b1;
            end
            if (hrise) begin
                if (!ref_valid) begin
                    line_ref  <= h_period;
                    ref_valid <= 1'b1;
                end else if (h_period != line_ref) begin
                    frame_ok <= 1'b0;
                end
            end
        end
    end

    lock_state_t      state;
    lock_state_t      state_nxt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_nxt;
    logic [MATCH_W-1:0] match_inc;
    logic             load_refs;
    logic             unlock_nxt;
    logic             frame_good;
    logic             same_timing;
    logic [CNT_W-1:0] h_ref;
    logic [CNT_W-1:0] v_ref;

    // A frame that overflowed the line counter cannot be measured either.
    assign frame_good  = frame_ok & ~frame_tmo & ~v_sat;
    assign same_timing = (line_ref == h_ref) && (v_meas == v_ref);
    assign match_inc   = match_cnt + MATCH_ONE;

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        match_nxt  = match_cnt;
        load_refs  = 1'b0;
        unlock_nxt = 1'b0;
        if (h_tmo) begin
            state_nxt  = ST_IDLE;
            match_nxt  = '0;
            unlock_nxt = (state == ST_LOCKED);
        end else if (vrise) begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ACQUIRE;
                    match_nxt = '0;
                end
                ST_ACQUIRE: begin
                    if (frame_good && ((match_cnt == '0) || same_timing)) begin
                        load_refs = 1'b1;
                        match_nxt = match_inc;
                        if (match_inc >= LOCK_TARGET) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else if (frame_good) begin
                        load_refs = 1'b1;
                        match_nxt = MATCH_ONE;
                    end else begin
                        match_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!(frame_good && same_timing)) begin
                        state_nxt  = ST_ACQUIRE;
                        unlock_nxt = 1'b1;
                        if (frame_good) begin
                            load_refs = 1'b1;
                            match_nxt = MATCH_ONE;
                        end else begin
                            match_nxt = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    match_nxt = '0;
                end
            endcase
        end
    end

    logic [23:0] rgb_d;

    // locked follows state_nxt so it rises on the same edge that enters LOCKED.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            h_ref        <= '0;
            v_ref        <= '0;
            locked       <= 1'b0;
            unlock_pulse <= 1'b0;
            rgb_d        <= '0;
        end else begin
            if (load_refs) begin
                h_ref <= line_ref;
                v_ref <= v_meas;
            end
            locked       <= (state_nxt == ST_LOCKED);
            unlock_pulse <= unlock_nxt;
            rgb_d        <= rgb_in;
        end
    end

    assign rgb_out       = locked ? rgb_d : 24'd0;
    assign h_total       = h_ref;
    assign v_total       = v_ref;
    assign state_dbg     = state;
    assign match_cnt_dbg = match_cnt;

endmodule
